// File: rtl/set_time_pkg.sv
// Shared constants, state encoding and BCD digit helpers for the set-time editor.
package set_time_pkg;

  // Bit positions within the 5-bit btn input.
  localparam int BTN_ENTER = 4;
  localparam int BTN_ESC   = 3;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 0;

  // Bit positions within the 6-bit press vector {enter, esc, up, down, left, right}.
  localparam int NUM_EVENTS = 6;
  localparam int EV_ENTER   = 5;
  localparam int EV_ESC     = 4;
  localparam int EV_UP      = 3;
  localparam int EV_DOWN    = 2;
  localparam int EV_LEFT    = 1;
  localparam int EV_RIGHT   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [3:0] MAX_H1       = 4'd2;
  localparam logic [3:0] MAX_H0       = 4'd9;
  localparam logic [3:0] MAX_H0_AT_20 = 4'd3;
  localparam logic [3:0] MAX_M1       = 4'd5;
  localparam logic [3:0] MAX_M0       = 4'd9;
  localparam logic [3:0] MAX_S1       = 4'd5;
  localparam logic [3:0] MAX_S0       = 4'd9;

  localparam logic [3:0] BLANK       = 4'ha;
  localparam logic [4:0] CURSOR_OFF  = 5'd31;
  localparam logic [2:0] CURSOR_LAST = 3'd5;

  function automatic logic [3:0] digit_max(input logic [2:0] idx, input logic [3:0] h1);
    case (idx)
      3'd5:    digit_max = MAX_H1;
      3'd4:    digit_max = (h1 == MAX_H1) ? MAX_H0_AT_20 : MAX_H0;
      3'd3:    digit_max = MAX_M1;
      3'd2:    digit_max = MAX_M0;
      3'd1:    digit_max = MAX_S1;
      default: digit_max = MAX_S0;
    endcase
  endfunction

  // Steps one BCD digit up or down with wrap; hours tens reaching 2 pulls hours units down to 3.
  function automatic logic [23:0] step_digit(input logic [23:0] t, input logic [2:0] idx,
                                             input logic up);
    logic [3:0]  d;
    logic [3:0]  mx;
    logic [23:0] r;
    r  = t;
    d  = t[{idx, 2'b00} +: 4];
    mx = digit_max(idx, t[23:20]);
    if (up) d = (d == mx) ? 4'd0 : d + 4'd1;
    else    d = (d == 4'd0) ? mx : d - 4'd1;
    r[{idx, 2'b00} +: 4] = d;
    if (idx == 3'd5 && r[23:20] == MAX_H1 && r[19:16] > MAX_H0_AT_20)
      r[19:16] = MAX_H0_AT_20;
    return r;
  endfunction

endpackage

// File: rtl/set_time_editor_btn_edge.sv
// Registered rising-edge detector for the debounced front-panel button levels.
module btn_edge
  import set_time_pkg::*;
#(
  parameter int W = NUM_EVENTS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic [W-1:0] press
);

  logic [W-1:0] level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      press   <= '0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/set_time_editor.sv
// Front-panel time editor: shadows the live time, lets the user step digits under a
// cursor, and commits the result to the timekeeper with a one-cycle load pulse.
module set_time_editor #(
  parameter logic [3:0] SET_MODE   = 4'd2,
  parameter logic [3:0] BLANK      = set_time_pkg::BLANK,
  parameter logic [4:0] CURSOR_OFF = set_time_pkg::CURSOR_OFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode,
  input  logic [4:0]  btn,
  input  logic        btn_right,
  input  logic [23:0] cur_time,
  output logic [31:0] disp_string,
  output logic [4:0]  count,
  output logic [23:0] time_out,
  output logic        time_load
);
  import set_time_pkg::*;

  state_t      state, state_n;
  logic [23:0] shadow, shadow_n;
  logic [2:0]  cursor, cursor_n;
  logic [23:0] time_out_n;
  logic [31:0] string_n;
  logic [4:0]  count_n;
  logic [NUM_EVENTS-1:0] press;

  btn_edge #(.W(NUM_EVENTS)) u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .level ({btn[BTN_ENTER], btn[BTN_ESC], btn[BTN_UP], btn[BTN_DOWN], btn[BTN_LEFT], btn_right}),
    .press (press)
  );

  // The if/else chain encodes press priority; leaving set mode outranks every press.
  always_comb begin
    state_n    = state;
    shadow_n   = shadow;
    cursor_n   = cursor;
    time_out_n = time_out;
    case (state)
      IDLE: begin
        if (press[EV_ENTER] && mode == SET_MODE) begin
          state_n  = EDIT;
          shadow_n = cur_time;
          cursor_n = CURSOR_LAST;
        end
      end
      EDIT: begin
        if (mode != SET_MODE)     state_n = IDLE;
        else if (press[EV_ENTER]) begin
          state_n    = COMMIT;
          time_out_n = shadow;
        end
        else if (press[EV_ESC])   state_n  = IDLE;
        else if (press[EV_UP])    shadow_n = step_digit(shadow, cursor, 1'b1);
        else if (press[EV_DOWN])  shadow_n = step_digit(shadow, cursor, 1'b0);
        else if (press[EV_LEFT])  cursor_n = (cursor == CURSOR_LAST) ? 3'd0 : cursor + 3'd1;
        else if (press[EV_RIGHT]) cursor_n = (cursor == 3'd0) ? CURSOR_LAST : cursor - 3'd1;
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    string_n = {BLANK, BLANK, shadow_n};
    count_n  = CURSOR_OFF;
    if (state_n == IDLE) string_n = {BLANK, BLANK, cur_time};
    if (state_n == EDIT) count_n  = {2'b00, cursor_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= 24'h000000;
      cursor      <= 3'd0;
      time_out    <= 24'h000000;
      time_load   <= 1'b0;
      disp_string <= {BLANK, BLANK, 24'h000000};
      count       <= CURSOR_OFF;
    end else begin
      state       <= state_n;
      shadow      <= shadow_n;
      cursor      <= cursor_n;
      time_out    <= time_out_n;
      time_load   <= (state_n == COMMIT);
      disp_string <= string_n;
      count       <= count_n;
    end
  end

endmodule

// File: tb/tb_set_time_editor.sv
// Randomized, model-checked bench for set_time_editor.
module tb_set_time_editor;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mode;
  logic [4:0]  btn;
  logic        btn_right;
  logic [23:0] cur_time;
  logic [31:0] disp_string;
  logic [4:0]  count;
  logic [23:0] time_out;
  logic        time_load;

  always #5 clk = ~clk;

  set_time_editor dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .btn         (btn),
    .btn_right   (btn_right),
    .cur_time    (cur_time),
    .disp_string (disp_string),
    .count       (count),
    .time_out    (time_out),
    .time_load   (time_load)
  );

  int total = 0;
  int bad   = 0;
  int loads = 0;
  logic [23:0] last_load = '0;

  // Reference model: edit flag, six decimal digits (index 0 = seconds units) and cursor.
  bit          m_edit = 0;
  int          dig[6];
  int          cur = 0;
  int          exp_loads = 0;
  logic [23:0] exp_load_val = '0;

  always @(negedge clk) begin
    if (time_load === 1'b1) begin
      loads++;
      last_load = time_out;
    end
  end

  function automatic int lim(int i);
    case (i)
      5:       return 2;
      4:       return (dig[5] == 2) ? 3 : 9;
      3, 1:    return 5;
      default: return 9;
    endcase
  endfunction

  function automatic logic [23:0] packed_shadow();
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'(dig[i]);
    return r;
  endfunction

  function automatic logic [31:0] exp_str();
    return m_edit ? {8'haa, packed_shadow()} : {8'haa, cur_time};
  endfunction

  function automatic logic [4:0] exp_cnt();
    return m_edit ? 5'(cur) : 5'd31;
  endfunction

  function automatic logic [23:0] rand_time();
    int h, m, s;
    h = $urandom_range(0, 23);
    m = $urandom_range(0, 59);
    s = $urandom_range(0, 59);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ev = {enter, esc, up, down, left, right}
  task automatic model_event(input logic [5:0] ev);
    int l;
    if (!m_edit) begin
      if (ev[5] && mode == 4'd2) begin
        m_edit = 1;
        for (int i = 0; i < 6; i++) dig[i] = int'(cur_time[i*4 +: 4]);
        cur = 5;
      end
    end
    else if (mode != 4'd2) m_edit = 0;
    else if (ev[5]) begin
      exp_loads++;
      exp_load_val = packed_shadow();
      m_edit = 0;
    end
    else if (ev[4]) m_edit = 0;
    else if (ev[3] || ev[2]) begin
      l = lim(cur);
      if (ev[3]) dig[cur] = (dig[cur] + 1) % (l + 1);
      else       dig[cur] = (dig[cur] + l) % (l + 1);
      if (dig[5] == 2 && dig[4] > 3) dig[4] = 3;
    end
    else if (ev[1]) cur = (cur + 1) % 6;
    else if (ev[0]) cur = (cur + 5) % 6;
  endtask

  task automatic pulse(input logic [5:0] ev);
    btn       = ev[5:1];
    btn_right = ev[0];
    tick();
    btn       = '0;
    btn_right = 1'b0;
    tick();
    model_event(ev);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 4'd2; btn = '0; btn_right = 1'b0; cur_time = 24'h134509;
    tick(); tick();
    total++; if (disp_string !== 32'haa000000) begin bad++; $display("[TB] FAIL reset_string got=%h exp=%h", disp_string, 32'haa000000); end
    total++; if (count !== 5'd31) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=31", count); end
    total++; if (time_load !== 1'b0) begin bad++; $display("[TB] FAIL reset_load got=%b exp=0", time_load); end
    total++; if (time_out !== 24'h0) begin bad++; $display("[TB] FAIL reset_time_out got=%h exp=000000", time_out); end
    rst = 1'b0;
    m_edit = 0;
    tick();
    total++; if (disp_string !== 32'haa134509) begin bad++; $display("[TB] FAIL idle_track got=%h exp=%h", disp_string, 32'haa134509); end
  endtask

  task automatic test_enter_latency();
    btn[4] = 1'b1;
    tick();
    total++; if (count !== 5'd31) begin bad++; $display("[TB] FAIL latency_edge1 got=%0d exp=31", count); end
    btn = '0;
    tick();
    model_event(6'b100000);
    total++; if (count !== 5'd5) begin bad++; $display("[TB] FAIL latency_edge2 got=%0d exp=5", count); end
    total++; if (disp_string !== 32'haa134509) begin bad++; $display("[TB] FAIL enter_string got=%h exp=%h", disp_string, 32'haa134509); end
    cur_time = 24'h010203;
    tick(); tick();
    total++; if (disp_string !== exp_str()) begin bad++; $display("[TB] FAIL shadow_hold got=%h exp=%h", disp_string, exp_str()); end
  endtask

  task automatic test_up_wrap();
    pulse(6'b001000);
    total++; if (disp_string !== 32'haa234509) begin bad++; $display("[TB] FAIL up_h1_to_2 got=%h exp=%h", disp_string, 32'haa234509); end
    pulse(6'b001000);
    total++; if (disp_string !== 32'haa034509) begin bad++; $display("[TB] FAIL up_h1_wrap got=%h exp=%h", disp_string, 32'haa034509); end
  endtask

  task automatic test_clamp_cursor();
    pulse(6'b010000);
    total++; if (count !== 5'd31) begin bad++; $display("[TB] FAIL esc_count got=%0d exp=31", count); end
    cur_time = 24'h195959;
    tick();
    pulse(6'b100000);
    pulse(6'b001000);
    total++; if (disp_string !== 32'haa235959) begin bad++; $display("[TB] FAIL h0_clamp got=%h exp=%h", disp_string, 32'haa235959); end
    pulse(6'b000010);
    total++; if (count !== 5'd0) begin bad++; $display("[TB] FAIL left_wrap got=%0d exp=0", count); end
    pulse(6'b000001);
    total++; if (count !== 5'd5) begin bad++; $display("[TB] FAIL right_wrap got=%0d exp=5", count); end
  endtask

  task automatic test_commit();
    int l0;
    l0 = loads;
    pulse(6'b100000);
    total++; if (loads - l0 !== 1) begin bad++; $display("[TB] FAIL commit_pulses got=%0d exp=1", loads - l0); end
    total++; if (last_load !== 24'h235959) begin bad++; $display("[TB] FAIL commit_value got=%h exp=235959", last_load); end
    total++; if (time_load !== 1'b0) begin bad++; $display("[TB] FAIL commit_load_drop got=%b exp=0", time_load); end
    cur_time = 24'h102030;
    tick(); tick();
    total++; if (count !== 5'd31) begin bad++; $display("[TB] FAIL commit_count got=%0d exp=31", count); end
    total++; if (disp_string !== 32'haa102030) begin bad++; $display("[TB] FAIL commit_track got=%h exp=%h", disp_string, 32'haa102030); end
  endtask

  task automatic test_abort();
    pulse(6'b100000);
    pulse(6'b010000);
    total++; if (count !== exp_cnt()) begin bad++; $display("[TB] FAIL esc_abort got=%0d exp=%0d", count, exp_cnt()); end
    pulse(6'b100000);
    total++; if (count !== 5'd5) begin bad++; $display("[TB] FAIL reenter got=%0d exp=5", count); end
    mode = 4'd0;
    tick(); tick();
    model_event(6'b000000);
    total++; if (count !== 5'd31) begin bad++; $display("[TB] FAIL mode_abort got=%0d exp=31", count); end
    pulse(6'b100000);
    total++; if (count !== 5'd31) begin bad++; $display("[TB] FAIL enter_wrong_mode got=%0d exp=31", count); end
    total++; if (loads !== exp_loads) begin bad++; $display("[TB] FAIL abort_loads got=%0d exp=%0d", loads, exp_loads); end
    mode = 4'd2;
    tick();
  endtask

  task automatic test_priority_reset();
    int l0;
    pulse(6'b100000);
    pulse(6'b101000);
    total++; if (last_load !== 24'h102030) begin bad++; $display("[TB] FAIL enter_beats_up got=%h exp=102030", last_load); end
    total++; if (loads !== exp_loads) begin bad++; $display("[TB] FAIL priority_loads got=%0d exp=%0d", loads, exp_loads); end
    pulse(6'b100000);
    l0 = loads;
    btn[4] = 1'b1;
    tick();
    btn = '0;
    rst = 1'b1;
    tick();
    total++; if (time_load !== 1'b0) begin bad++; $display("[TB] FAIL rst_commit_load got=%b exp=0", time_load); end
    total++; if (disp_string !== 32'haa000000) begin bad++; $display("[TB] FAIL rst_commit_string got=%h exp=%h", disp_string, 32'haa000000); end
    total++; if (time_out !== 24'h0) begin bad++; $display("[TB] FAIL rst_commit_out got=%h exp=000000", time_out); end
    rst = 1'b0;
    m_edit = 0;
    tick(); tick();
    total++; if (loads !== l0) begin bad++; $display("[TB] FAIL rst_commit_pulses got=%0d exp=%0d", loads, l0); end
  endtask

  task automatic test_random_edit();
    logic [5:0] ev;
    cur_time = rand_time();
    tick();
    pulse(6'b100000);
    for (int n = 0; n < 60; n++) begin
      cur_time = rand_time();
      ev = {2'b00, 4'($urandom_range(1, 15))};
      pulse(ev);
      total++; if (disp_string !== exp_str()) begin bad++; $display("[TB] FAIL rand_string[%0d] got=%h exp=%h", n, disp_string, exp_str()); end
      total++; if (count !== exp_cnt()) begin bad++; $display("[TB] FAIL rand_count[%0d] got=%0d exp=%0d", n, count, exp_cnt()); end
    end
    pulse(6'b100000);
    total++; if (last_load !== exp_load_val) begin bad++; $display("[TB] FAIL rand_commit got=%h exp=%h", last_load, exp_load_val); end
    total++; if (loads !== exp_loads) begin bad++; $display("[TB] FAIL rand_loads got=%0d exp=%0d", loads, exp_loads); end
  endtask

  initial begin
    test_reset();
    test_enter_latency();
    test_up_wrap();
    test_clamp_cursor();
    test_commit();
    test_abort();
    test_priority_reset();
    test_random_edit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
